// File: rtl/divider.sv
// Multi-cycle restoring integer divider (DIV / DIVU).
// Accepts operands on a one-cycle start pulse in IDLE, performs one
// restoring step per clock in CALC, applies sign correction in FIX and
// returns {remainder, quotient} with a one-cycle valid pulse.
module divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      sign,
  input  logic [DATA_WIDTH-1:0]     Operand1,
  input  logic [DATA_WIDTH-1:0]     Operand2,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      valid,
  output logic                      busy,
  output logic                      div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Control state
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  result_q;
  logic            valid_q;
  logic            busy_q;
  logic            dbz_q;

  // Datapath state: operand magnitudes and sign information
  logic [W-1:0]    rem_q;
  logic [W-1:0]    quo_q;
  logic [W-1:0]    dvs_q;
  logic            sign_q;
  logic            neg1_q;
  logic            neg2_q;

  // Next-step and correction values
  logic [W:0]      shift_d;
  logic [W:0]      diff_d;
  logic [W-1:0]    rem_d;
  logic [W-1:0]    quo_d;
  logic [W-1:0]    rem_fix_d;
  logic [W-1:0]    quo_fix_d;
  logic            dbz_d;

  // Two's complement negation modulo 2^W.
  function automatic logic [W-1:0] neg2c(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand: absolute value for signed ops, raw otherwise.
  // The most-negative value maps onto itself, which reads correctly as
  // the unsigned magnitude 2^(W-1).
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x,
                                             input logic        is_signed);
    return (is_signed && x[W-1]) ? neg2c(x) : x;
  endfunction

  // One restoring step: shift {rem, quo} left, subtract if it fits.
  always_comb begin
    shift_d = {rem_q, quo_q[W-1]};
    diff_d  = shift_d - {1'b0, dvs_q};
    if (shift_d >= {1'b0, dvs_q}) begin
      rem_d = diff_d[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_d = shift_d[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b0};
    end
  end

  // Final sign correction; divide-by-zero keeps the all-ones quotient and
  // restores the original dividend as remainder.
  always_comb begin
    dbz_d = (dvs_q == '0);
    // With a zero divisor every step subtracts nothing, so rem_q holds the
    // dividend magnitude; re-applying the dividend sign recovers the
    // dividend exactly as supplied.
    rem_fix_d = (sign_q && neg1_q) ? neg2c(rem_q) : rem_q;
    if (dbz_d) begin
      quo_fix_d = '1;
    end else begin
      quo_fix_d = (sign_q && (neg1_q ^ neg2_q)) ? neg2c(quo_q) : quo_q;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CALC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= {rem_fix_d, quo_fix_d};
          dbz_q    <= dbz_d;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath registers: load magnitudes on an accepted start, step in CALC.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && start) begin
      rem_q  <= '0;
      quo_q  <= magnitude(Operand1, sign);
      dvs_q  <= magnitude(Operand2, sign);
      sign_q <= sign;
      neg1_q <= Operand1[W-1];
      neg2_q <= Operand2[W-1];
    end else if (state_q == CALC) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign result      = result_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_divider;

  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RST;
  logic           start;
  logic           sign;
  logic [W-1:0]   Operand1;
  logic [W-1:0]   Operand2;
  logic [2*W-1:0] result;
  logic           valid;
  logic           busy;
  logic           div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] last_res;

  divider #(.DATA_WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .sign        (sign),
    .Operand1    (Operand1),
    .Operand2    (Operand2),
    .result      (result),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, remainder, quotient} from plain arithmetic.
  function automatic logic [64:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        s);
    longint q;
    longint r;
    logic [63:0] qv;
    logic [63:0] rv;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = $signed({32'd0, a}) / $signed({32'd0, b});
      r = $signed({32'd0, a}) % $signed({32'd0, b});
    end
    qv = q;
    rv = r;
    return {1'b0, rv[31:0], qv[31:0]};
  endfunction

  // Issue one operation now (between edges) and check it end to end.
  // k>0 re-pulses start with (ia, ib) k cycles after the accepting edge.
  // Returns at #1 after the valid edge, i.e. inside the valid cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int k,
                        input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input string tag);
    logic [64:0] e;
    e = ref_div(a, b, s);
    start = 1'b1; sign = s; Operand1 = a; Operand2 = b;
    @(posedge CLK); #1;
    start = 1'b0;
    Operand1 = $urandom; Operand2 = $urandom; sign = 1'($urandom_range(0, 1));
    chk({tag, " busy@E+1"}, 64'(busy), 64'd1);
    chk({tag, " valid@E+1"}, 64'(valid), 64'd0);
    for (int i = 1; i <= W; i++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (i == k) begin
        start = 1'b1; Operand1 = ia; Operand2 = ib;
      end
      if (i == W) begin
        chk({tag, " valid@E+W"}, 64'(valid), 64'd0);
        chk({tag, " busy@E+W"}, 64'(busy), 64'd1);
      end
    end
    @(posedge CLK); #1;
    chk({tag, " valid"}, 64'(valid), 64'd1);
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    chk({tag, " result"}, result, e[63:0]);
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(e[64]));
    last_res = result;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'(-$urandom_range(1, 100));
      5: return 32'($urandom_range(0, 1000));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int vcount;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    RST = 1'b0; start = 1'b0; sign = 1'b0; Operand1 = '0; Operand2 = '0;
    #1;
    chk("reset result", result, 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    #21 RST = 1'b1;
    idle(1);

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, 0, '0, '0, "divu100_7");
    chk("divu100_7 lit", last_res, 64'h00000002_0000000E);
    idle(2);
    run_op(-32'sd7, 32'd2, 1'b1, 0, '0, '0, "div-7_2");
    chk("div-7_2 lit", last_res, 64'hFFFFFFFF_FFFFFFFD);
    run_op(32'd7, -32'sd2, 1'b1, 0, '0, '0, "div7_-2");
    chk("div7_-2 lit", last_res, 64'h00000001_FFFFFFFD);
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0, '0, '0, "divu_ff_10");
    chk("divu_ff_10 lit", last_res, 64'h0000000F_0FFFFFFF);
    run_op(32'hFFFF_FFFF, 32'h10, 1'b1, 0, '0, '0, "div_ff_10");
    chk("div_ff_10 lit", last_res, 64'hFFFFFFFF_00000000);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, '0, '0, "div_ovf");
    chk("div_ovf lit", last_res, 64'h00000000_80000000);
    chk("div_ovf noflag", 64'(div_by_zero), 64'd0);
    run_op(32'd5, 32'd0, 1'b1, 0, '0, '0, "div5_0");
    chk("div5_0 lit", last_res, 64'h00000005_FFFFFFFF);
    chk("div5_0 flag", 64'(div_by_zero), 64'd1);
    run_op(-32'sd5, 32'd0, 1'b1, 0, '0, '0, "div-5_0");
    chk("div-5_0 lit", last_res, 64'hFFFFFFFB_FFFFFFFF);
    idle(1);
    chk("dbz retained", 64'(div_by_zero), 64'd1);
    chk("result retained", result, 64'hFFFFFFFB_FFFFFFFF);

    // Handshake: ignored mid-op start, then back-to-back start in valid cycle
    run_op(32'd8, 32'd3, 1'b0, 10, 32'd50, 32'd5, "hs_ignore");
    chk("hs_ignore lit", last_res, 64'h00000002_00000002);
    run_op(32'd50, 32'd5, 1'b0, 0, '0, '0, "hs_b2b");
    chk("hs_b2b lit", last_res, 64'h00000000_0000000A);
    idle(1);
    chk("valid one cycle", 64'(valid), 64'd0);

    // Reset in the middle of an operation
    run_op(32'd5, 32'd0, 1'b1, 0, '0, '0, "pre_rst");
    idle(1);
    start = 1'b1; sign = 1'b0; Operand1 = 32'd100; Operand2 = 32'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (14) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rst mid result", result, 64'd0);
    chk("rst mid valid", 64'(valid), 64'd0);
    chk("rst mid busy", 64'(busy), 64'd0);
    chk("rst mid dbz", 64'(div_by_zero), 64'd0);
    idle(3);
    RST = 1'b1;
    vcount = 0;
    repeat (W + 5) begin
      @(posedge CLK); #1;
      if (valid) vcount++;
    end
    chk("rst no valid", 64'(vcount), 64'd0);
    chk("rst idle busy", 64'(busy), 64'd0);
    run_op(32'd9, 32'd4, 1'b0, 0, '0, '0, "post_rst");
    chk("post_rst lit", last_res, 64'h00000001_00000002);

    // Randomized operations, some back-to-back
    for (int n = 0; n < 60; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      run_op(ra, rb, rs, 0, '0, '0, $sformatf("rnd%0d", n));
    end
    idle(1);
    chk("final valid low", 64'(valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Multi-cycle sequential integer divider for the multi-cycle MIPS datapath, the inverse-operation partner of the multiplier and sharing its start/valid handshake. It accepts a dividend and divisor on a one-cycle `start` pulse, runs one restoring-division step per clock, and returns `{remainder, quotient}` in a double-width result that maps directly onto HI/LO. It supports both DIV (signed) and DIVU (unsigned), and reports divide-by-zero.

## Interface
- `DATA_WIDTH`, default 32, operand width W; result is 2W.
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `Operand1`  in  W  dividend; sampled with `start`.
- `Operand2`  in  W  divisor; sampled with `start`.
- `result`  out  2W  `{remainder[W-1:0], quotient[W-1:0]}` (upper half → HI, lower half → LO).
- `valid`  out  1  one-cycle pulse: `result` and `div_by_zero` are updated and valid.
- `busy`  out  1  high in CALC and FIX.
- `div_by_zero`  out  1  divisor was zero for the operation just completed; updated with `valid`.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE + `start`=1**
  - Latch `sign` and the sign bits of both operands.
  - Latch the operand magnitudes: absolute value if `sign`=1, raw value otherwise.
  - Clear the partial remainder, set the iteration counter to 0, go to CALC.
- **IDLE + `start`=0:** hold.
- **CALC:** one restoring step per cycle.
  - Shift `{rem, quo}` left by 1, bringing in the dividend MSB.
  - If `rem` ≥ divisor magnitude: subtract and set the quotient LSB to 1.
  - The counter increments every cycle. After the W-th step, go to FIX.
  - The counter is ceil(log2 W)+1 bits wide.
- **FIX:** write `result` and `div_by_zero`, assert `valid`, go to IDLE.
  - **Normal case:** quotient is negated iff `sign` and dividend sign ≠ divisor sign. Remainder is negated iff `sign` and dividend is negative (remainder takes the dividend's sign). All negation is two's complement modulo 2^W.
  - **Divisor = 0:** quotient = all ones, remainder = original dividend as supplied, `div_by_zero`=1. No sign correction is applied. Latency is unchanged.
  - **Signed overflow (most-negative / −1):** quotient = most-negative value, remainder = 0, no flag. This falls out naturally from magnitude arithmetic.
- **Handshake rules**
  - `start` in CALC or FIX is ignored; no queueing.
  - `start` in the IDLE cycle in which `valid` is high is accepted normally.
- **Output retention:** `result` and `div_by_zero` hold their values until the next FIX. Operand inputs may change freely after the `start` edge.
- **Reset** (async, any state including mid-CALC): state = IDLE, counter = 0, `result` = 0, `valid` = 0, `busy` = 0, `div_by_zero` = 0. The in-flight operation is discarded and no `valid` is produced for it.

## Timing
- Let edge E be the rising edge that samples `start`=1 in IDLE.
- `busy` is high from after E until after edge E+W+1.
- `valid`, `result` and `div_by_zero` update at edge E+W+1. `valid` is high for exactly one cycle and falls at edge E+W+2.
- Latency is W+1 cycles (33 for W=32), independent of operand values.
- Back-to-back operation: `start` in the cycle where `valid`=1 gives the next `valid` W+1 cycles later. Sustained throughput is one operation per W+1 cycles.
- Reset assertion takes effect without a clock edge. After deassertion, the first `start` is accepted on the next rising edge.

## Test plan
- **Unsigned basic:** DIVU 100 / 7 → `valid` 33 cycles after start edge; `result` = {32'd2, 32'd14}; `div_by_zero`=0.
- **Signed mixed signs:** DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- **Signed mixed signs:** DIV 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Unsigned vs signed same bits:** DIVU 0xFFFFFFFF / 0x10 → {0x0000000F, 0x0FFFFFFF}. DIV with the same operands → {0xFFFFFFFF, 0x00000000}.
- **Boundaries**
  - DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}, no flag.
  - DIV 5 / 0 → {0x00000005, 0xFFFFFFFF}, `div_by_zero`=1, still 33-cycle latency.
  - DIV −5 / 0 → remainder 0xFFFFFFFB.
- **Handshake:** DIVU 8 / 3 started; `start` re-pulsed with 50 / 5 at cycle 10 → ignored, result {2, 2} at cycle 33. Then `start` with 50 / 5 during the `valid` cycle → {0, 10} exactly 33 cycles later.
- **Reset mid-operation:** assert `RST`=0 at cycle 15 of a 100 / 7 divide → outputs 0 immediately, no `valid`. After release, DIVU 9 / 4 → {1, 2} after 33 cycles.
